// File: rtl/ram_read_arbiter.sv
// Two-requester read arbiter in front of a registered-output RAM.
// One transaction in flight: grant and strobe in IDLE, response held in RESPOND.
module ram_read_arbiter #(
  parameter int unsigned RamSize       = 4096,
  parameter bit          FixedPriority = 1'b0
) (
  input  logic        clock_i,
  input  logic        reset_i,

  input  logic        req0_valid_i,
  input  logic [31:0] req0_address_i,
  output logic        req0_ready_o,
  input  logic        req1_valid_i,
  input  logic [31:0] req1_address_i,
  output logic        req1_ready_o,

  output logic        rsp0_valid_o,
  output logic [31:0] rsp0_data_o,
  output logic        rsp0_error_o,
  input  logic        rsp0_ready_i,
  output logic        rsp1_valid_o,
  output logic [31:0] rsp1_data_o,
  output logic        rsp1_error_o,
  input  logic        rsp1_ready_i,

  output logic        ram_read_enable_o,
  output logic [31:0] ram_address_o,
  input  logic [31:0] ram_data_i
);

  typedef enum logic {
    IDLE    = 1'b0,
    RESPOND = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q;
  logic        grant_id_q;
  logic        grant_error_q;

  logic        any_valid;
  logic        pick;
  logic [31:0] pick_address;
  logic        pick_error;
  logic        grant;
  logic        granted_rsp_ready;

  // Arbitration and error classification for the candidate of this cycle.
  always_comb begin
    any_valid = req0_valid_i | req1_valid_i;
    if (req0_valid_i && req1_valid_i) begin
      pick = FixedPriority ? 1'b0 : ~last_grant_q;
    end else begin
      pick = ~req0_valid_i;
    end
    pick_address      = pick ? req1_address_i : req0_address_i;
    pick_error        = (pick_address[1:0] != 2'b00) || (pick_address >= 32'(RamSize));
    grant             = (state_q == IDLE) && any_valid && !reset_i;
    granted_rsp_ready = grant_id_q ? rsp1_ready_i : rsp0_ready_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      grant_id_q    <= 1'b0;
      grant_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        last_grant_q  <= pick;
        grant_id_q    <= pick;
        grant_error_q <= pick_error;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_valid)         state_d = RESPOND;
      RESPOND: if (granted_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The RAM stays unstrobed in RESPOND, so ram_data_i is stable while held.
  always_comb begin
    req0_ready_o      = 1'b0;
    req1_ready_o      = 1'b0;
    ram_read_enable_o = 1'b0;
    ram_address_o     = '0;
    rsp0_valid_o      = 1'b0;
    rsp0_data_o       = '0;
    rsp0_error_o      = 1'b0;
    rsp1_valid_o      = 1'b0;
    rsp1_data_o       = '0;
    rsp1_error_o      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          req0_ready_o = ~pick;
          req1_ready_o = pick;
          if (!pick_error) begin
            ram_read_enable_o = 1'b1;
            ram_address_o     = pick_address;
          end
        end
      end
      RESPOND: begin
        if (grant_id_q) begin
          rsp1_valid_o = 1'b1;
          rsp1_data_o  = grant_error_q ? 32'h0 : ram_data_i;
          rsp1_error_o = grant_error_q;
        end else begin
          rsp0_valid_o = 1'b1;
          rsp0_data_o  = grant_error_q ? 32'h0 : ram_data_i;
          rsp0_error_o = grant_error_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_read_arbiter.sv
// Bench for ram_read_arbiter: a round-robin and a fixed-priority instance share
// the request stimulus; responses are checked against a queue of expected reads.
module tb_ram_read_arbiter;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        error;
  } rsp_t;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic [1:0]  req_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] req_addr [2];

  logic [1:0]  rr_ready, rr_rsp_valid, rr_rsp_error;
  logic [31:0] rr_rsp_data0, rr_rsp_data1, rr_raddr;
  logic        rr_ren;
  logic [31:0] rr_ramdata = '0;

  logic [1:0]  fp_ready, fp_rsp_valid, fp_rsp_error;
  logic [31:0] fp_rsp_data0, fp_rsp_data1, fp_raddr;
  logic        fp_ren;
  logic [31:0] fp_ramdata = '0;

  logic [34:0] rr_grant_bus, fp_grant_bus;
  logic [67:0] rr_rsp_bus;

  rsp_t sb [$];
  int   tests = 0;
  int   fails = 0;

  always #5 clock_i = ~clock_i;

  assign rr_grant_bus = {rr_ready, rr_ren, rr_raddr};
  assign fp_grant_bus = {fp_ready, fp_ren, fp_raddr};
  assign rr_rsp_bus   = {rr_rsp_valid, rr_rsp_error, rr_rsp_data1, rr_rsp_data0};

  ram_read_arbiter #(.RamSize(4096), .FixedPriority(1'b0)) u_rr (
    .clock_i(clock_i), .reset_i(reset_i),
    .req0_valid_i(req_valid[0]), .req0_address_i(req_addr[0]), .req0_ready_o(rr_ready[0]),
    .req1_valid_i(req_valid[1]), .req1_address_i(req_addr[1]), .req1_ready_o(rr_ready[1]),
    .rsp0_valid_o(rr_rsp_valid[0]), .rsp0_data_o(rr_rsp_data0), .rsp0_error_o(rr_rsp_error[0]),
    .rsp0_ready_i(rsp_ready[0]),
    .rsp1_valid_o(rr_rsp_valid[1]), .rsp1_data_o(rr_rsp_data1), .rsp1_error_o(rr_rsp_error[1]),
    .rsp1_ready_i(rsp_ready[1]),
    .ram_read_enable_o(rr_ren), .ram_address_o(rr_raddr), .ram_data_i(rr_ramdata)
  );

  ram_read_arbiter #(.RamSize(4096), .FixedPriority(1'b1)) u_fp (
    .clock_i(clock_i), .reset_i(reset_i),
    .req0_valid_i(req_valid[0]), .req0_address_i(req_addr[0]), .req0_ready_o(fp_ready[0]),
    .req1_valid_i(req_valid[1]), .req1_address_i(req_addr[1]), .req1_ready_o(fp_ready[1]),
    .rsp0_valid_o(fp_rsp_valid[0]), .rsp0_data_o(fp_rsp_data0), .rsp0_error_o(fp_rsp_error[0]),
    .rsp0_ready_i(rsp_ready[0]),
    .rsp1_valid_o(fp_rsp_valid[1]), .rsp1_data_o(fp_rsp_data1), .rsp1_error_o(fp_rsp_error[1]),
    .rsp1_ready_i(rsp_ready[1]),
    .ram_read_enable_o(fp_ren), .ram_address_o(fp_raddr), .ram_data_i(fp_ramdata)
  );

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    if (a[31:2] == 30'd4) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Registered-output RAM models: data appears the cycle after the strobe and is held.
  always @(posedge clock_i) if (rr_ren) rr_ramdata <= ram_word(rr_raddr);
  always @(posedge clock_i) if (fp_ren) fp_ramdata <= ram_word(fp_raddr);

  function automatic logic is_error(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'd4096);
  endfunction

  function automatic logic [34:0] grant_exp(input logic id, input logic [31:0] a);
    logic err;
    err = is_error(a);
    return {(id ? 2'b10 : 2'b01), !err, (err ? 32'h0 : a)};
  endfunction

  function automatic logic [67:0] rsp_exp(input rsp_t e);
    logic [1:0] v;
    v = e.id ? 2'b10 : 2'b01;
    return {v, (e.error ? v : 2'b00), (e.id ? e.data : 32'h0), (e.id ? 32'h0 : e.data)};
  endfunction

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  // Samples mid-cycle; a round-robin grant enqueues the response it must produce.
  task automatic sample();
    rsp_t e;
    @(negedge clock_i);
    if (rr_ready != 2'b00) begin
      e.id    = rr_ready[1];
      e.error = is_error(req_addr[e.id]);
      e.data  = e.error ? 32'h0 : ram_word(req_addr[e.id]);
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    sb.delete();
    reset_i = 1'b1; req_valid = 2'b11; rsp_ready = 2'b00;
    req_addr[0] = 32'h10; req_addr[1] = 32'h14;
    tick();
    sample();
    tests++;
    if ({rr_grant_bus, fp_grant_bus} !== 70'h0) begin
      fails++;
      $display("FAIL reset_gate: got %h/%h expected 0/0", rr_grant_bus, fp_grant_bus);
    end
    tick();
    reset_i = 1'b0; req_valid = 2'b00;
    sample();
    tests++;
    if ({rr_rsp_bus, rr_grant_bus, fp_rsp_valid, fp_grant_bus} !== 140'h0) begin
      fails++;
      $display("FAIL post_reset_outputs: got rsp %h grant %h fp %b/%h expected all 0",
               rr_rsp_bus, rr_grant_bus, fp_rsp_valid, fp_grant_bus);
    end
    tick();
  endtask

  task automatic test_single_read();
    rsp_t e;
    req_valid = 2'b01; req_addr[0] = 32'h10; rsp_ready = 2'b11;
    sample();
    tests++;
    if (rr_grant_bus !== grant_exp(1'b0, 32'h10)) begin
      fails++;
      $display("FAIL v1_grant: got %h expected %h", rr_grant_bus, grant_exp(1'b0, 32'h10));
    end
    tick();
    req_valid = 2'b00;
    sample();
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL v1_response: got no queued grant expected one");
    end else begin
      e = sb.pop_front();
      if (rr_rsp_bus !== rsp_exp(e)) begin
        fails++;
        $display("FAIL v1_response: got %h expected %h", rr_rsp_bus, rsp_exp(e));
      end
    end
    tick();
    sample();
    tests++;
    if ({rr_rsp_bus, rr_grant_bus} !== 103'h0) begin
      fails++;
      $display("FAIL v1_idle: got rsp %h grant %h expected 0", rr_rsp_bus, rr_grant_bus);
    end
    tick();
  endtask

  task automatic test_arbitration();
    rsp_t e;
    logic want_id;
    reset_i = 1'b1; req_valid = 2'b00;
    tick();
    reset_i = 1'b0;
    sb.delete();
    req_valid = 2'b11; req_addr[0] = 32'h20; req_addr[1] = 32'h24; rsp_ready = 2'b11;
    for (int c = 0; c < 8; c++) begin
      sample();
      if (c % 2 == 0) begin
        want_id = ((c / 2) % 2) == 1;
        tests++;
        if (rr_grant_bus !== grant_exp(want_id, req_addr[want_id])) begin
          fails++;
          $display("FAIL rr_grant[%0d]: got %h expected %h", c, rr_grant_bus,
                   grant_exp(want_id, req_addr[want_id]));
        end
        tests++;
        if (fp_ready !== 2'b01) begin
          fails++;
          $display("FAIL fp_grant[%0d]: got %b expected 01", c, fp_ready);
        end
      end else begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL rr_response[%0d]: got no queued grant expected one", c);
        end else begin
          e = sb.pop_front();
          if ({rr_rsp_bus, rr_grant_bus} !== {rsp_exp(e), 35'h0}) begin
            fails++;
            $display("FAIL rr_response[%0d]: got %h/%h expected %h/0", c, rr_rsp_bus,
                     rr_grant_bus, rsp_exp(e));
          end
        end
        tests++;
        if (fp_rsp_valid !== 2'b01) begin
          fails++;
          $display("FAIL fp_response[%0d]: got %b expected 01", c, fp_rsp_valid);
        end
      end
      tick();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_error();
    rsp_t        e;
    logic        ids   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] addrs [4] = '{32'h1002, 32'h1000, 32'h0FFC, 32'h11};
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      req_addr[ids[i]] = addrs[i];
      req_valid = ids[i] ? 2'b10 : 2'b01;
      sample();
      tests++;
      if (rr_grant_bus !== grant_exp(ids[i], addrs[i])) begin
        fails++;
        $display("FAIL err_grant[%h]: got %h expected %h", addrs[i], rr_grant_bus,
                 grant_exp(ids[i], addrs[i]));
      end
      tick();
      req_valid = 2'b00;
      sample();
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL err_response[%h]: got no queued grant expected one", addrs[i]);
      end else begin
        e = sb.pop_front();
        if ({rr_rsp_bus, rr_ren} !== {rsp_exp(e), 1'b0}) begin
          fails++;
          $display("FAIL err_response[%h]: got %h/%b expected %h/0", addrs[i], rr_rsp_bus,
                   rr_ren, rsp_exp(e));
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    rsp_t e;
    req_valid = 2'b01; req_addr[0] = 32'h10; req_addr[1] = 32'h30; rsp_ready = 2'b10;
    sample();
    tests++;
    if (rr_grant_bus !== grant_exp(1'b0, 32'h10)) begin
      fails++;
      $display("FAIL bp_grant: got %h expected %h", rr_grant_bus, grant_exp(1'b0, 32'h10));
    end
    tick();
    req_valid = 2'b10;
    for (int i = 0; i < 5; i++) begin
      sample();
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got no queued grant expected one", i);
      end else if ({rr_rsp_bus, rr_grant_bus} !== {rsp_exp(sb[0]), 35'h0}) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got %h/%h expected %h/0", i, rr_rsp_bus, rr_grant_bus,
                 rsp_exp(sb[0]));
      end
      tick();
    end
    rsp_ready = 2'b01;
    sample();
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL bp_complete: got no queued grant expected one");
    end else begin
      e = sb.pop_front();
      if (rr_rsp_bus !== rsp_exp(e)) begin
        fails++;
        $display("FAIL bp_complete: got %h expected %h", rr_rsp_bus, rsp_exp(e));
      end
    end
    tick();
    sample();
    tests++;
    if (rr_grant_bus !== grant_exp(1'b1, 32'h30)) begin
      fails++;
      $display("FAIL bp_next_grant: got %h expected %h", rr_grant_bus, grant_exp(1'b1, 32'h30));
    end
    tick();
    req_valid = 2'b00; rsp_ready = 2'b11;
    sample();
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL bp_next_response: got no queued grant expected one");
    end else begin
      e = sb.pop_front();
      if (rr_rsp_bus !== rsp_exp(e)) begin
        fails++;
        $display("FAIL bp_next_response: got %h expected %h", rr_rsp_bus, rsp_exp(e));
      end
    end
    tick();
  endtask

  task automatic test_reset_respond();
    rsp_t e;
    req_valid = 2'b01; req_addr[0] = 32'h40; rsp_ready = 2'b11;
    sample();
    tests++;
    if (rr_grant_bus !== grant_exp(1'b0, 32'h40)) begin
      fails++;
      $display("FAIL v6_grant: got %h expected %h", rr_grant_bus, grant_exp(1'b0, 32'h40));
    end
    tick();
    reset_i = 1'b1; req_valid = 2'b11; rsp_ready = 2'b00;
    sample();
    tests++;
    if (rr_grant_bus !== 35'h0) begin
      fails++;
      $display("FAIL v6_reset_gate: got %h expected 0", rr_grant_bus);
    end
    tick();
    reset_i = 1'b0; req_valid = 2'b00; rsp_ready = 2'b11;
    sb.delete();
    sample();
    tests++;
    if ({rr_rsp_bus, rr_grant_bus} !== 103'h0) begin
      fails++;
      $display("FAIL v6_cleared: got rsp %h grant %h expected 0", rr_rsp_bus, rr_grant_bus);
    end
    tick();
    req_valid = 2'b11; req_addr[0] = 32'h44; req_addr[1] = 32'h48;
    sample();
    tests++;
    if (rr_grant_bus !== grant_exp(1'b0, 32'h44)) begin
      fails++;
      $display("FAIL v6_tie: got %h expected %h", rr_grant_bus, grant_exp(1'b0, 32'h44));
    end
    tick();
    req_valid = 2'b00;
    sample();
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL v6_response: got no queued grant expected one");
    end else begin
      e = sb.pop_front();
      if (rr_rsp_bus !== rsp_exp(e)) begin
        fails++;
        $display("FAIL v6_response: got %h expected %h", rr_rsp_bus, rsp_exp(e));
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_arbitration();
    test_error();
    test_backpressure();
    test_reset_respond();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
